// File: rtl/divr2_core.sv
// Iterative radix-2 restoring divider (signed/unsigned) with a one-cycle done pulse.
// Optional early-out for divide-by-zero and |dividend| < |divisor|: define DIVR2_EARLY_OUT_EN.
module divr2_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] zdividend,
  input  logic [WIDTH-1:0] zdivisor,
  input  logic             valid_in,
  input  logic             sign,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             free,
  output logic             sign_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
`ifdef DIVR2_EARLY_OUT_EN
    BYPASS,
`endif
    POST
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo;      // dividend bits shift out MSB-first, quotient bits shift in
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] dvd_raw;
  logic             qneg, rneg, divzero, mode;

  logic             accept;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh, diff;
  logic             step_ok;
  logic             early;

  assign free   = (state == IDLE);
  assign accept = valid_in & free;

  always_comb begin
    a_abs   = (sign & zdividend[WIDTH-1]) ? -zdividend : zdividend;
    b_abs   = (sign & zdivisor[WIDTH-1])  ? -zdivisor  : zdivisor;
    rem_sh  = {rem, quo[WIDTH-1]};
    diff    = rem_sh - {1'b0, dsr};
    step_ok = ~diff[WIDTH];
`ifdef DIVR2_EARLY_OUT_EN
    early   = (zdivisor == '0) || (a_abs < b_abs);
`else
    early   = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef DIVR2_EARLY_OUT_EN
          state_nxt = early ? BYPASS : ITER;
`else
          state_nxt = ITER;
`endif
        end
      end
      ITER:   if (count == LAST) state_nxt = POST;
`ifdef DIVR2_EARLY_OUT_EN
      BYPASS: state_nxt = POST;
`endif
      POST:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      quo     <= '0;
      rem     <= '0;
      dsr     <= '0;
      dvd_raw <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      divzero <= 1'b0;
      mode    <= 1'b0;
      q       <= '0;
      r       <= '0;
      done    <= 1'b0;
      sign_o  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            count   <= '0;
            dsr     <= b_abs;
            dvd_raw <= zdividend;
            qneg    <= sign & (zdividend[WIDTH-1] ^ zdivisor[WIDTH-1]);
            rneg    <= sign & zdividend[WIDTH-1];
            divzero <= (zdivisor == '0);
            mode    <= sign;
            // Bypass preloads the final magnitudes: quotient 0, remainder |dividend|.
            if (early) begin
              quo <= '0;
              rem <= a_abs;
            end else begin
              quo <= a_abs;
              rem <= '0;
            end
          end
        end
        ITER: begin
          quo   <= {quo[WIDTH-2:0], step_ok};
          rem   <= step_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          count <= count + CW'(1);
        end
        POST: begin
          done   <= 1'b1;
          sign_o <= mode;
          if (divzero) begin
            q <= '1;
            r <= dvd_raw;
          end else begin
            q <= qneg ? -quo : quo;
            r <= rneg ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divr2_core.sv
// Scoreboard bench for divr2_core: driver pushes expected results, negedge monitor pops on done.
module tb_divr2_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] zdividend = '0;
  logic [31:0] zdivisor  = '0;
  logic        valid_in  = 1'b0;
  logic        sign      = 1'b0;
  logic [31:0] q, r;
  logic        done, free, sign_o;

  divr2_core #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .zdividend(zdividend), .zdivisor(zdivisor),
    .valid_in(valid_in), .sign(sign), .q(q), .r(r), .done(done),
    .free(free), .sign_o(sign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        s;
    int unsigned due;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division, truncating toward zero in signed mode.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input int unsigned now);
    exp_t   e;
    longint sa, sb;
    logic [31:0] ua, ub;
    bit     early_hit;
    e.a = a;
    e.b = b;
    e.s = s;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (!s) begin
      e.q = a / b;
      e.r = a % b;
    end else begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      e.q = 32'(sa / sb);
      e.r = 32'(sa % sb);
    end
    ua = (s && a[31]) ? (32'd0 - a) : a;
    ub = (s && b[31]) ? (32'd0 - b) : b;
    early_hit = (b == 32'd0) || (ua < ub);
`ifdef DIVR2_EARLY_OUT_EN
    e.due = now + 1 + (early_hit ? 2 : 33);
`else
    e.due = now + 1 + 33 + (early_hit ? 0 : 0);
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL missing_done a=%h b=%h: no done by cycle %0d, required at %0d",
                 exp_q[0].a, exp_q[0].b, cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_done at cycle %0d: q=%h r=%h, required no done", cyc, q, r);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_cmp++;
          if (q !== e.q || r !== e.r || sign_o !== e.s) begin
            n_bad++;
            $display("FAIL result a=%h b=%h s=%0b: got q=%h r=%h sign_o=%0b, required q=%h r=%h sign_o=%0b",
                     e.a, e.b, e.s, q, r, sign_o, e.q, e.r, e.s);
          end
          n_cmp++;
          if (cyc != e.due) begin
            n_bad++;
            $display("FAIL latency a=%h b=%h: done at cycle %0d, required %0d", e.a, e.b, cyc, e.due);
          end
          n_cmp++;
          if (free !== 1'b1) begin
            n_bad++;
            $display("FAIL free_in_done: got free=%0b, required 1", free);
          end
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    n_cmp++;
    if ({q, r, done, free, sign_o} !== {32'd0, 32'd0, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL %s: got q=%h r=%h done=%0b free=%0b sign_o=%0b, required 0/0/0/1/0",
               tag, q, r, done, free, sign_o);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    int unsigned guard = 0;
    @(negedge clk);
    while (!free && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!free) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: free stayed %0b, required 1 within 200 cycles", free);
      return;
    end
    zdividend = a;
    zdivisor  = b;
    sign      = s;
    valid_in  = 1'b1;
    exp_q.push_back(model(a, b, s, cyc));
    @(negedge clk);
    valid_in  = 1'b0;
    zdividend = $urandom;
    zdivisor  = $urandom;
    n_cmp++;
    if (free !== 1'b0) begin
      n_bad++;
      $display("FAIL free_after_accept: got free=%0b, required 0", free);
    end
  endtask

  task automatic stream(input int unsigned n);
    logic [31:0] a, b;
    logic        s;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      s = 1'($urandom_range(0, 1));
      zdividend = a;
      zdivisor  = b;
      sign      = s;
      valid_in  = 1'b1;
      if (free) exp_q.push_back(model(a, b, s, cyc));
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  function automatic logic [31:0] rand_divisor(input logic [31:0] a, input logic s);
    logic [31:0] b;
    case ($urandom_range(0, 3))
      0: b = 32'($urandom_range(1, 15));
      1: b = $urandom;
      2: b = a >> $urandom_range(0, 31);
      default: b = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'hFFFF_FFFF;
    endcase
    if (s && $urandom_range(0, 1) == 1) b = 32'd0 - b;
    return b;
  endfunction

  initial begin
    logic [31:0] a;
    logic        s;
    int unsigned guard;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset_state");
    rst = 1'b0;

    send(32'd100, 32'd7, 1'b0);
    send(32'hFFFF_FFF9, 32'd2, 1'b1);
    send(32'd7, 32'hFFFF_FFFE, 1'b1);
    send(32'd5, 32'd0, 1'b0);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    send(32'hFFFF_FFFF, 32'd1, 1'b0);
    send(32'd3, 32'd10, 1'b0);
    send(32'd5, 32'd0, 1'b1);
    send(32'd0, 32'd0, 1'b0);
    send(32'hFFFF_FFF9, 32'd0, 1'b1);
    send(32'h8000_0000, 32'd1, 1'b1);
    send(32'd100, 32'd7, 1'b0);

    for (int unsigned i = 0; i < 40; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      send(a, rand_divisor(a, s), s);
    end

    stream(150);

    // Abort an operation 10 cycles after accept.
    send(32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state("reset_mid_op");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    send(32'd9, 32'd4, 1'b0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divr2_core.md
Name: divr2_core

Overview:
- Iterative radix-2 restoring integer divider. It is the responder on the divr2 request/result interface that the testbench drives.
- Accepts one 32-bit dividend/divisor pair per operation in signed or unsigned mode. Returns quotient and remainder with a one-cycle done pulse.
- Advertises readiness on free.
- Sits behind the testbench clocking block today; later it sits behind a core's execute stage.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- zdividend  input  WIDTH  dividend, sampled on accept
- zdivisor  input  WIDTH  divisor, sampled on accept
- valid_in  input  1  request strobe
- sign  input  1  1 = two's-complement signed operation, 0 = unsigned
- q  output  WIDTH  quotient, valid when done=1, held until next result
- r  output  WIDTH  remainder, valid when done=1, held until next result
- done  output  1  one-cycle result pulse
- free  output  1  1 = request will be accepted this cycle
- sign_o  output  1  sign mode of the operation whose result is on q/r

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, q=0, r=0, done=0, free=1, sign_o=0, counter=0. Any in-flight operation is discarded and produces no done.
- Accept: rising edge with valid_in=1 and free=1, edge E0.
  - Latch absolute values of both operands; in unsigned mode these are the raw values.
  - Latch qneg = sign & (dividend[MSB] ^ divisor[MSB]) and rneg = sign & dividend[MSB].
  - Latch divzero = (zdivisor==0) and the sign mode.
  - free drops to 0 after E0.
- valid_in while free=0: ignored, with no side effects.
- States:
  - IDLE: wait for accept, then go to ITER with count=0.
  - ITER: one restoring step per cycle.
    - Shift the partial remainder left, bringing in the next dividend bit MSB-first.
    - Trial-subtract the divisor using a WIDTH+1-bit subtract.
    - If non-negative, keep the difference and set the quotient bit to 1; otherwise keep the remainder and set the bit to 0.
    - After WIDTH steps (edges E1..E32 for WIDTH=32), go to POST.
  - POST: write q and r and assert done for exactly one cycle; sign_o = latched mode. This happens after edge E0+WIDTH+1, i.e. latency 33 cycles for WIDTH=32, independent of operand values. Then return to IDLE.
- Sign fix in POST: q = qneg ? -qmag : qmag; r = rneg ? -rmag : rmag.
- Divide by zero (divzero=1), signed or unsigned: q = all ones, r = original zdividend unmodified. Latency is the same as normal.
- Signed overflow (0x80000000 / 0xFFFFFFFF): q = 0x80000000, r = 0. This falls out of the unsigned magnitude path with no special case required; the bench must confirm it.
- free rises in the same cycle done is high. A valid_in in the done cycle is accepted at the next edge, giving back-to-back operation with no gap.
- q, r and sign_o are unchanged outside POST writes.

Optional Feature:
- Macro: DIVR2_EARLY_OUT_EN.
- Defined:
  - At accept, if divzero=1 or |dividend| < |divisor| (unsigned magnitude compare), skip ITER and go IDLE→POST.
  - done is asserted after edge E0+2, i.e. latency 2 cycles.
  - Results follow the same rules as above: for |dividend|<|divisor|, q=0 and r=dividend with sign fix, i.e. r = zdividend.
- Not defined: every operation takes the fixed WIDTH+1 cycles. The comparator and bypass logic are absent.

Test Plan:
1. Unsigned: sign=0, zdividend=100, zdivisor=7, valid_in one cycle → free=0 next cycle; done 33 cycles after accept with q=14, r=2, sign_o=0; free=1 in the done cycle.
2. Signed: sign=1, zdividend=0xFFFFFFF9 (-7), zdivisor=2 → q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1), sign_o=1. Repeat with 7/-2 → q=0xFFFFFFFD, r=1.
3. Corner values:
   - 5/0 unsigned → q=0xFFFFFFFF, r=5.
   - 0x80000000/0xFFFFFFFF signed → q=0x80000000, r=0.
   - 0xFFFFFFFF/1 unsigned → q=0xFFFFFFFF, r=0.
4. Handshake:
   - Hold valid_in=1 continuously with changing operands: only the operand present at each accept edge is used.
   - Requests arriving while busy are dropped.
   - A second request in the done cycle completes 33 cycles later.
5. Reset mid-operation: assert rst 10 cycles after accepting 100/7 → q=0, r=0, done=0, free=1 immediately. No done appears for the aborted operation. A following 9/4 gives q=2, r=1.
6. With DIVR2_EARLY_OUT_EN: 3/10 unsigned → done 2 cycles after accept, q=0, r=3. 5/0 → done 2 cycles after accept, q=0xFFFFFFFF, r=5. 100/7 still takes 33 cycles.
